if_id_skid_reg: RTL and testbench

Parametrised IF→ID pipeline register with a valid/ready handshake, a 2-entry skid buffer and a flush input. It sits between the fetch stage and the decode stage and replaces the plain always-advance IF/ID register. Fetch and decode can now stall independently, and a taken branch or exception can discard in-flight instructions. When the buffer is empty it presents a bubble: PC 0 and a configurable NOP.

---
 rtl/if_id_skid_reg.sv | 64 ++++++
 tb/tb_if_id_skid_reg.sv | 125 ++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer and flush
module if_id_skid_reg #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter logic [INST_W-1:0]    NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [1:0]        fill_o
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic              up_fire, dn_fire, load_in_main, load_skid_main, load_skid;
  assign if_ready_o = state_q != FULL;
  assign id_valid_o = state_q != EMPTY;
  assign id_pc_o    = id_valid_o ? main_pc_q : '0;
  assign id_inst_o  = id_valid_o ? main_inst_q : NOP_INST;
  assign fill_o     = state_q;
  assign up_fire    = if_valid_i & if_ready_o;
  assign dn_fire    = id_valid_o & id_ready_i;
  // next occupancy and data movement; flush empties the buffer and drops any same-cycle input
  always_comb begin
    load_in_main   = up_fire & ((state_q == EMPTY) | dn_fire);
    load_skid      = up_fire & (state_q == ONE) & ~dn_fire;
    load_skid_main = (state_q == FULL) & dn_fire;
    state_d        = flush_i ? EMPTY :
                     (state_q == EMPTY) ? (up_fire ? ONE : EMPTY) :
                     (state_q == ONE) ? (load_skid ? FULL : (dn_fire & ~up_fire) ? EMPTY : ONE) :
                     (dn_fire ? ONE : FULL);
    main_pc_d      = load_skid_main ? skid_pc_q : load_in_main ? if_pc_i : main_pc_q;
    main_inst_d    = load_skid_main ? skid_inst_q : load_in_main ? if_inst_i : main_inst_q;
    skid_pc_d      = load_skid ? if_pc_i : skid_pc_q;
    skid_inst_d    = load_skid ? if_inst_i : skid_inst_q;
  end
  // state and entry registers; reset discards everything immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: queue-model checker plus directed literal checks for if_id_skid_reg
module tb_if_id_skid_reg;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, if_valid = 1'b0, id_ready = 1'b1;
  logic [31:0] if_pc = '0, if_inst = '0;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [1:0]  fill;
  int          vecs = 0, errs = 0;
  bit          saw_300 = 1'b0;
  ent_t        q[$];
  logic [31:0] log_q[$];
  if_id_skid_reg #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(if_ready),
    .if_pc_i(if_pc), .if_inst_i(if_inst), .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .fill_o(fill)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // model: a FIFO of at most two entries; decode pops the head, fetch pushes when fewer than two held
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      automatic bit up = if_valid && q.size() < 2;
      automatic bit dn = q.size() > 0 && id_ready;
      if (dn) begin
        log_q.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (up) q.push_back('{if_pc, if_inst});
    end
  end
  // compare outputs against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("id_valid", id_valid, q.size() > 0);
      chk("if_ready", if_ready, q.size() < 2);
      chk("fill", fill, q.size());
      chk("id_pc", id_pc, q.size() > 0 ? q[0].pc : 32'h0);
      chk("id_inst", id_inst, q.size() > 0 ? q[0].inst : NOP);
      if (id_valid && id_pc == 32'h300) saw_300 = 1'b1;
    end
  end
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    if_valid = v; if_pc = pc; if_inst = inst; id_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst_nop", id_inst, 32'h13);
    chk("rst_ready", if_ready, 1'b1);
    chk("rst_fill", fill, 2'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 32'h100, 32'hA, 1, 0);
    chk("stream_first_pc", id_pc, 32'h100);
    chk("stream_first_fill", fill, 2'd1);
    drive(1, 32'h104, 32'hB, 1, 0);
    drive(1, 32'h108, 32'hC, 1, 0);
    chk("stream_last_inst", id_inst, 32'hC);
    drive(0, 0, 0, 1, 0);
    chk("stream_order", {log_q[0], log_q[1], log_q[2]}, {32'h100, 32'h104, 32'h108});
    log_q.delete();
    drive(1, 32'h200, 32'h20, 1, 0);
    drive(1, 32'h204, 32'h24, 0, 0);
    chk("bp_fill2", fill, 2'd2);
    chk("bp_ready0", if_ready, 1'b0);
    drive(1, 32'h208, 32'h28, 0, 0);
    chk("bp_hold1", id_pc, 32'h200);
    drive(1, 32'h208, 32'h28, 0, 0);
    chk("bp_hold2", id_pc, 32'h200);
    drive(1, 32'h208, 32'h28, 1, 0);
    chk("bp_recover_ready", if_ready, 1'b1);
    chk("bp_recover_pc", id_pc, 32'h204);
    drive(1, 32'h208, 32'h28, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("bp_count", log_q.size(), 3);
    chk("bp_order", {log_q[0], log_q[1], log_q[2]}, {32'h200, 32'h204, 32'h208});
    drive(1, 32'h2F0, 32'h30, 0, 0);
    drive(1, 32'h2F4, 32'h34, 0, 0);
    chk("fl_pre_full", fill, 2'd2);
    drive(1, 32'h300, 32'h3F, 0, 1);
    chk("fl_valid0", id_valid, 1'b0);
    chk("fl_fill0", fill, 2'd0);
    chk("fl_ready1", if_ready, 1'b1);
    drive(1, 32'h400, 32'h40, 0, 0);
    chk("redirect_pc", id_pc, 32'h400);
    chk("redirect_valid", id_valid, 1'b1);
    drive(0, 0, 0, 1, 1);
    chk("fl_consume_log", log_q[log_q.size()-1], 32'h400);
    chk("fl_consume_empty", id_valid, 1'b0);
    for (int i = 0; i < 80; i++)
      drive($urandom_range(0, 3) != 0, 32'h1000 + 4 * i, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
    chk("no_300", saw_300, 1'b0);
    drive(1, 32'h500, 32'h50, 0, 0);
    drive(1, 32'h504, 32'h54, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", id_valid, 1'b0);
    chk("async_pc", id_pc, 32'h0);
    chk("async_inst", id_inst, 32'h13);
    chk("async_ready", if_ready, 1'b1);
    chk("async_fill", fill, 2'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
